// File: rtl/i2s_mono_ctrl_if.sv
// i2s_mono_ctrl_if: lane pins plus TX/RX PCM streams between controller and its peers
//   lane   : bclk, lrclk, push, pop, tx_pcm (ctrl->lane); full, rx_pcm (lane->ctrl)
//   TX in  : s_valid, s_data (source->ctrl); s_ready (ctrl->source)
//   RX out : m_valid, m_data (ctrl->sink); m_ready (sink->ctrl)
interface i2s_mono_ctrl_if;
    logic        bclk;
    logic        lrclk;
    logic        full;
    logic        push;
    logic        pop;
    logic [15:0] rx_pcm;
    logic [15:0] tx_pcm;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    modport master (
        output bclk, lrclk, push, pop, tx_pcm, s_ready, m_valid, m_data,
        input  full, rx_pcm, s_valid, s_data, m_ready
    );
    modport slave (
        input  bclk, lrclk, push, pop, tx_pcm, s_ready, m_valid, m_data,
        output full, rx_pcm, s_valid, s_data, m_ready
    );
endinterface

// File: rtl/i2s_mono_ctrl.sv
// i2s_mono_ctrl: master-mode bclk/lrclk generator and PCM stream bridge for one i2s_mono lane
//   clk, rstn          system clock, async active-low reset
//   enable             run request; start/stop only on frame boundaries
//   sel_rx, div        lane direction and bclk half-period (div+1 clk), sampled in IDLE
//   running            high in START/RUN/DRAIN
//   bus                lane pins plus TX (s_*) and RX (m_*) streams
//   underrun, overrun  saturating event counters
module i2s_mono_ctrl #(
    parameter int DIV_W     = 8,
    parameter int SLOT_BITS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             sel_rx,
    input  logic [DIV_W-1:0] div,
    output logic             running,
    i2s_mono_ctrl_if.master  bus,
    output logic [CNT_W-1:0] underrun,
    output logic [CNT_W-1:0] overrun
);
    localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;
    state_t           state, state_d;
    logic [DIV_W-1:0] div_q, divcnt;
    logic [BIT_W-1:0] bitcnt;
    logic             sel_q, bclk_q, lrclk_q, push_q, pop_q, pend, m_valid_q;
    logic [15:0]      tx_q, m_data_q;
    logic             active, div_wrap, bclk_fall, slot_end, frame_end, svc;
    assign active    = state == RUN || state == DRAIN;
    assign div_wrap  = active && divcnt == div_q;
    assign bclk_fall = div_wrap && bclk_q;
    assign slot_end  = bclk_fall && bitcnt == BIT_W'(SLOT_BITS - 1);
    // the right slot ending brings lrclk back to 0: a whole frame is complete
    assign frame_end = slot_end && lrclk_q;
    // pend blocks a second service until the lane has dropped full
    assign svc       = active && bus.full && !pend;
    assign running     = state != IDLE;
    assign bus.bclk    = bclk_q;
    assign bus.lrclk   = lrclk_q;
    assign bus.push    = push_q;
    assign bus.pop     = pop_q;
    assign bus.tx_pcm  = tx_q;
    assign bus.s_ready = svc && !sel_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = enable ? START : IDLE;
            START:   state_d = RUN;
            RUN:     state_d = enable ? RUN : DRAIN;
            default: state_d = enable ? RUN : (frame_end ? IDLE : DRAIN);
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            div_q     <= '0;
            divcnt    <= '0;
            bitcnt    <= '0;
            sel_q     <= 1'b0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            pend      <= 1'b0;
            tx_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            underrun  <= '0;
            overrun   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                sel_q <= sel_rx;
                div_q <= div;
            end
            if (state == START) begin
                divcnt  <= '0;
                bitcnt  <= '0;
                bclk_q  <= 1'b0;
                lrclk_q <= 1'b0;
            end else if (active) begin
                divcnt <= div_wrap ? '0 : divcnt + 1'b1;
                if (div_wrap) bclk_q <= ~bclk_q;
                if (bclk_fall) bitcnt <= slot_end ? '0 : bitcnt + 1'b1;
                if (slot_end) lrclk_q <= ~lrclk_q;
            end
            pend <= (state == START) ? 1'b0 : (svc || (pend && bus.full));
            if (svc && !sel_q) begin
                push_q <= ~push_q;
                tx_q   <= bus.s_valid ? bus.s_data : '0;
                if (!bus.s_valid && !(&underrun)) underrun <= underrun + 1'b1;
            end
            if (svc && sel_q) begin
                pop_q <= ~pop_q;
                if (!m_valid_q || bus.m_ready) begin
                    m_data_q  <= bus.rx_pcm;
                    m_valid_q <= 1'b1;
                end else if (!(&overrun)) begin
                    overrun <= overrun + 1'b1;
                end
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_mono_ctrl.sv
// tb_i2s_mono_ctrl: randomized self-checking bench acting as lane, TX source and RX sink
module tb_i2s_mono_ctrl;
    localparam int SLOT = 32;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        sel_rx = 1'b0;
    logic [7:0]  div = 8'd0;
    logic        running;
    logic [15:0] underrun, overrun;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] loop_q[$];
    i2s_mono_ctrl_if bus ();
    i2s_mono_ctrl #(.DIV_W(8), .SLOT_BITS(SLOT), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .sel_rx(sel_rx), .div(div),
        .running(running), .bus(bus), .underrun(underrun), .overrun(overrun)
    );
    always #5 clk = ~clk;

    task automatic start_run(input logic mode);
        sel_rx = mode;
        div = 8'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic stop_run;
        int n;
        n = 0;
        enable = 1'b0;
        while (running && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL stop_timeout running=%b after %0d cycles, need 0", running, n);
        end
    endtask

    task automatic lane_tx(input logic sv, input logic [15:0] sd, output logic sr,
                           output bit lat, output logic [15:0] got, output int ntog, output bit pop_moved);
        logic pp, p0;
        p0 = bus.pop;
        pp = bus.push;
        ntog = 0;
        bus.s_valid = sv;
        bus.s_data = sd;
        bus.full = 1'b1;
        #1 sr = bus.s_ready;
        @(negedge clk);
        lat = bus.push !== pp;
        pp = bus.push;
        got = bus.tx_pcm;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (bus.push !== pp) ntog++;
            pp = bus.push;
        end
        bus.full = 1'b0;
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            if (bus.push !== pp) ntog++;
            pp = bus.push;
        end
        pop_moved = bus.pop !== p0;
    endtask

    task automatic lane_rx(input logic [15:0] w, output bit lat, output logic [15:0] md,
                           output logic mv, output int ntog, output bit push_moved);
        logic pp, p0;
        p0 = bus.push;
        pp = bus.pop;
        ntog = 0;
        bus.rx_pcm = w;
        bus.full = 1'b1;
        @(negedge clk);
        lat = bus.pop !== pp;
        pp = bus.pop;
        md = bus.m_data;
        mv = bus.m_valid;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (bus.pop !== pp) ntog++;
            pp = bus.pop;
        end
        bus.full = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            if (bus.pop !== pp) ntog++;
            pp = bus.pop;
        end
        push_moved = bus.push !== p0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({running, bus.bclk, bus.lrclk, bus.push, bus.pop, bus.s_ready, bus.m_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b need 0000000",
                     {running, bus.bclk, bus.lrclk, bus.push, bus.pop, bus.s_ready, bus.m_valid});
        end
        checks++;
        if (bus.tx_pcm !== 16'h0 || bus.m_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data tx_pcm=%h m_data=%h need 0", bus.tx_pcm, bus.m_data);
        end
        checks++;
        if (underrun !== 16'h0 || overrun !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters underrun=%0d overrun=%0d need 0", underrun, overrun);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clock(input int d);
        int cyc, drop_at, falls, last_rise, bper, bad_b, lr_first, lr_r1, lr_r2;
        logic pb, pl;
        bit stopped, idle_bad, run_bad;
        div = 8'(d);
        sel_rx = 1'b0;
        idle_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.bclk !== 1'b0 || bus.lrclk !== 1'b0 || running !== 1'b0) idle_bad = 1;
        end
        checks++;
        if (idle_bad) begin
            errors++;
            $display("FAIL clk_idle_hold bclk/lrclk/running moved before start, need all 0");
        end
        drop_at = 200 * (d + 1) + 20 + int'($urandom_range(0, 60));
        pb = 1'b0; pl = 1'b0; falls = 0; last_rise = -1; bper = -1; bad_b = 0;
        lr_first = -1; lr_r1 = -1; lr_r2 = -1; stopped = 0; run_bad = 0;
        enable = 1'b1;
        for (cyc = 1; cyc < drop_at + 20000 && !stopped; cyc++) begin
            @(negedge clk);
            if (bus.bclk && !pb) begin
                if (last_rise >= 0) begin
                    if (bper < 0) bper = cyc - last_rise;
                    else if (cyc - last_rise != bper) bad_b++;
                end
                last_rise = cyc;
            end
            if (!bus.bclk && pb) falls++;
            if (bus.lrclk !== pl) begin
                if (lr_first < 0) lr_first = falls;
                if (bus.lrclk) begin
                    if (lr_r1 < 0) lr_r1 = cyc;
                    else if (lr_r2 < 0) lr_r2 = cyc;
                end
            end
            pb = bus.bclk;
            pl = bus.lrclk;
            if (cyc <= drop_at && !running) run_bad = 1;
            if (cyc > drop_at && !running) stopped = 1;
            if (cyc == drop_at) enable = 1'b0;
        end
        checks++;
        if (bper !== 2 * (d + 1)) begin
            errors++;
            $display("FAIL clk_bclk_period div=%0d got %0d need %0d", d, bper, 2 * (d + 1));
        end
        checks++;
        if (bad_b !== 0) begin
            errors++;
            $display("FAIL clk_bclk_jitter div=%0d got %0d uneven periods need 0", d, bad_b);
        end
        checks++;
        if (lr_first !== SLOT) begin
            errors++;
            $display("FAIL clk_first_lrclk div=%0d got %0d bclk falls need %0d", d, lr_first, SLOT);
        end
        checks++;
        if (lr_r2 - lr_r1 !== 4 * SLOT * (d + 1)) begin
            errors++;
            $display("FAIL clk_lrclk_period div=%0d got %0d need %0d", d, lr_r2 - lr_r1, 4 * SLOT * (d + 1));
        end
        checks++;
        if (run_bad) begin
            errors++;
            $display("FAIL clk_running_early running dropped before enable low, need 1");
        end
        checks++;
        if (!stopped || falls % (2 * SLOT) != 0) begin
            errors++;
            $display("FAIL clk_stop_frame stopped=%0d falls=%0d need whole frames of %0d", stopped, falls, 2 * SLOT);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({running, bus.bclk, bus.lrclk} !== 3'b000) begin
            errors++;
            $display("FAIL clk_after_stop running/bclk/lrclk=%b need 000", {running, bus.bclk, bus.lrclk});
        end
    endtask

    task automatic test_tx_stream;
        logic sr;
        bit lat, pm;
        logic [15:0] got, w;
        int ntog;
        start_run(1'b0);
        for (int k = 1; k <= 6; k++) begin
            w = 16'(k * 16'h0100);
            lane_tx(1'b1, w, sr, lat, got, ntog, pm);
            checks++;
            if (!(sr === 1'b1 && lat && ntog == 0 && !pm)) begin
                errors++;
                $display("FAIL tx_handshake word %0d s_ready=%b latency_ok=%0d extra_toggles=%0d pop_moved=%0d need 1 1 0 0",
                         k, sr, lat, ntog, pm);
            end
            checks++;
            if (got !== w) begin
                errors++;
                $display("FAIL tx_data word %0d got %h need %h", k, got, w);
            end
            loop_q.push_back(got);
        end
        checks++;
        if (underrun !== 16'd0) begin
            errors++;
            $display("FAIL tx_no_underrun got %0d need 0", underrun);
        end
    endtask

    task automatic test_tx_underrun;
        logic sr;
        bit lat, pm;
        logic [15:0] got;
        int ntog;
        for (int k = 0; k < 3; k++) begin
            lane_tx(1'b0, 16'($urandom), sr, lat, got, ntog, pm);
            checks++;
            if (got !== 16'h0 || !lat) begin
                errors++;
                $display("FAIL tx_underrun_word %0d tx_pcm=%h toggled=%0d need 0000 1", k, got, lat);
            end
        end
        checks++;
        if (underrun !== 16'd3) begin
            errors++;
            $display("FAIL tx_underrun_count got %0d need 3", underrun);
        end
    endtask

    task automatic test_tx_random;
        logic sr, sv;
        bit lat, pm;
        logic [15:0] got, w, exp_w;
        int ntog, exp_u;
        exp_u = 3;
        for (int k = 0; k < 10; k++) begin
            sv = 1'($urandom_range(0, 1));
            w = 16'($urandom);
            exp_w = sv ? w : 16'h0;
            if (!sv) exp_u++;
            lane_tx(sv, w, sr, lat, got, ntog, pm);
            checks++;
            if (got !== exp_w || !lat || ntog != 0) begin
                errors++;
                $display("FAIL tx_random word %0d got %h need %h toggled=%0d extra=%0d", k, got, exp_w, lat, ntog);
            end
        end
        checks++;
        if (underrun !== 16'(exp_u)) begin
            errors++;
            $display("FAIL tx_random_underrun got %0d need %0d", underrun, exp_u);
        end
        stop_run();
    endtask

    task automatic test_rx_loop;
        bit lat, pm;
        logic [15:0] md;
        logic mv;
        int ntog;
        bus.m_ready = 1'b1;
        start_run(1'b1);
        foreach (loop_q[i]) begin
            lane_rx(loop_q[i], lat, md, mv, ntog, pm);
            checks++;
            if (md !== loop_q[i] || mv !== 1'b1 || !lat || ntog != 0 || pm) begin
                errors++;
                $display("FAIL rx_loop word %0d m_data=%h m_valid=%b toggled=%0d extra=%0d push_moved=%0d need %h 1 1 0 0",
                         i, md, mv, lat, ntog, pm, loop_q[i]);
            end
        end
        checks++;
        if (bus.m_valid !== 1'b0 || overrun !== 16'd0) begin
            errors++;
            $display("FAIL rx_loop_end m_valid=%b overrun=%0d need 0 0", bus.m_valid, overrun);
        end
    endtask

    task automatic test_rx_overrun;
        bit lat, pm;
        logic [15:0] md, w0, w;
        logic mv;
        int ntog, pops;
        bus.m_ready = 1'b0;
        pops = 0;
        w0 = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            w = (k == 0) ? w0 : 16'($urandom);
            lane_rx(w, lat, md, mv, ntog, pm);
            pops += int'(lat) + ntog;
        end
        checks++;
        if (bus.m_data !== w0 || bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_hold m_data=%h m_valid=%b need %h 1", bus.m_data, bus.m_valid, w0);
        end
        checks++;
        if (overrun !== 16'd3) begin
            errors++;
            $display("FAIL rx_overrun got %0d need 3", overrun);
        end
        checks++;
        if (pops != 4) begin
            errors++;
            $display("FAIL rx_pop_count got %0d need 4", pops);
        end
        bus.m_ready = 1'b1;
        w = 16'($urandom);
        lane_rx(w, lat, md, mv, ntog, pm);
        checks++;
        if (md !== w || mv !== 1'b1 || overrun !== 16'd3) begin
            errors++;
            $display("FAIL rx_simultaneous m_data=%h m_valid=%b overrun=%0d need %h 1 3", md, mv, overrun, w);
        end
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_clear m_valid=%b need 0", bus.m_valid);
        end
    endtask

    task automatic test_async_reset;
        bit lat, pm;
        logic [15:0] md;
        logic mv;
        int ntog;
        bus.m_ready = 1'b0;
        lane_rx(16'hA5A5, lat, md, mv, ntog, pm);
        repeat ($urandom_range(3, 40)) @(negedge clk);
        checks++;
        if (running !== 1'b1 || bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre running=%b m_valid=%b need 1 1", running, bus.m_valid);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({running, bus.bclk, bus.lrclk, bus.push, bus.pop, bus.s_ready, bus.m_valid} !== 7'b0 ||
            bus.tx_pcm !== 16'h0 || bus.m_data !== 16'h0 || underrun !== 16'h0 || overrun !== 16'h0) begin
            errors++;
            $display("FAIL areset_outputs flags=%b tx=%h md=%h un=%0d ov=%0d need all 0",
                     {running, bus.bclk, bus.lrclk, bus.push, bus.pop, bus.s_ready, bus.m_valid},
                     bus.tx_pcm, bus.m_data, underrun, overrun);
        end
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({running, bus.bclk, bus.lrclk} !== 3'b000) begin
            errors++;
            $display("FAIL areset_idle running/bclk/lrclk=%b need 000", {running, bus.bclk, bus.lrclk});
        end
    endtask

    initial begin
        bus.full = 1'b0;
        bus.rx_pcm = 16'h0;
        bus.s_valid = 1'b0;
        bus.s_data = 16'h0;
        bus.m_ready = 1'b0;
        test_reset();
        test_clock(3);
        test_clock(int'($urandom_range(0, 2)));
        test_tx_stream();
        test_tx_underrun();
        test_tx_random();
        test_rx_loop();
        test_rx_overrun();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
